fpnew_result_rob: RTL and testbench
===================================

FPNEW_RESULT_ROB -- requirements
Module: fpnew_result_rob

Interface
REQ-001 SHALL have parameter Width, default 32, result data width.
REQ-002 SHALL have parameter Depth, default 4, number of reorder slots; power of two, >=2.
REQ-003 SHALL define localparam IdxW = $clog2(Depth), the tag width.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush_i  input  1  discard all in-flight entries.
REQ-007 SHALL have ports in_valid_i  input  1 and in_ready_o  output  1: core issue handshake.
REQ-008 SHALL have ports op_valid_o  output  1, op_ready_i  input  1 and op_tag_o  output  IdxW: issue toward the opgroup blocks; op_tag_o is the allocated slot.
REQ-009 SHALL have ports res_valid_i  input  1, res_ready_o  output  1, res_tag_i  input  IdxW, res_result_i  input  Width and res_status_i  input  fpnew_pkg::status_t: out-of-order results from the opgroup blocks.
REQ-010 SHALL have ports out_valid_o  output  1, out_ready_i  input  1, out_result_o  output  Width and out_status_o  output  fpnew_pkg::status_t: in-order writeback.
REQ-011 SHALL have ports busy_o  output  1 (any slot allocated) and err_o  output  1 (sticky protocol error).

Function
REQ-012 SHALL keep head and tail pointers of IdxW+1 bits (wrap bit); full = pointers differ only in MSB; empty = pointers equal.
REQ-013 SHALL drive op_valid_o = in_valid_i & ~full & ~flush_i, in_ready_o = op_ready_i & ~full & ~flush_i, and op_tag_o = tail[IdxW-1:0].
REQ-014 SHALL allocate on in_valid_i & in_ready_o: slot[tail] pending=1, done=0; tail increments modulo 2*Depth.
REQ-015 SHALL compute full from registered state only; a retire and an allocation never share a freed slot in the same cycle.
REQ-016 SHALL hold res_ready_o = 1 at all times.
REQ-017 SHALL, on res_valid_i to a slot with pending=1 and done=0, store result and status and set done=1 at the next edge.
REQ-018 SHALL, on res_valid_i to a slot not pending or already done, drop the result and set err_o, which holds until reset.
REQ-019 SHALL drive out_valid_o = slot[head].done, with out_result_o and out_status_o taken from slot[head].
REQ-020 SHALL, on out_valid_o & out_ready_i, clear slot[head] pending and done and increment head.
REQ-021 SHALL allow allocation, result capture and retire in the same cycle on different slots.
REQ-022 SHALL retire in strict allocation order; a completed non-head slot waits indefinitely.
REQ-023 SHALL latency: result captured at edge N gives out_valid_o in cycle N+1 when that slot is head.
REQ-024 SHALL, on flush_i, hold out_valid_o = 0 combinationally, drop results without setting err_o, and at the next edge clear all slots and zero both pointers.
REQ-025 SHALL drive busy_o = ~empty.

Reset
REQ-026 SHALL, on rst_ni low, clear head, tail, all pending and done bits, and err_o immediately (asynchronous) without waiting for a clock edge.
REQ-027 SHALL drive out_valid_o = 0, busy_o = 0, err_o = 0 and in_ready_o = op_ready_i after reset.
REQ-028 SHALL leave result and status storage unreset.

Configuration
REQ-029 SHALL, with FPNEW_ROB_BYPASS_EN defined, forward res_result_i and res_status_i to the outputs in the same cycle when res_tag_i matches head, the head is pending and not done, and flush_i = 0.
REQ-030 SHALL, with bypass active and out_ready_i = 1, retire the entry that cycle without writing it.
REQ-031 SHALL, with bypass active and out_ready_i = 0, store the result as in REQ-017.
REQ-032 SHALL, without FPNEW_ROB_BYPASS_EN, keep latency at exactly one cycle per REQ-023.

Verification
REQ-033 SHALL check in-order delivery: Depth=4, issue tags 0,1,2,3; return results 2,0,3,1 with result=tag+100 -> out sequence 100,101,102,103 and err_o=0.
REQ-034 SHALL check full back-pressure: 4 issued, none returned -> in_ready_o=0; return tag 0, retire it -> in_ready_o=1 on the following cycle and the next op_tag_o=0.
REQ-035 SHALL check a duplicate result: second result for tag 1 while done -> result dropped, err_o=1 until rst_ni low.
REQ-036 SHALL check flush: 3 entries in flight, flush_i pulse -> next cycle busy_o=0, out_valid_o=0; late result for tag 2 -> err_o=1.
REQ-037 SHALL check bypass: FPNEW_ROB_BYPASS_EN defined, out_ready_i=1, head result 0x3F800000 -> out_valid_o same cycle, status passes unchanged; undefined -> appears one cycle later.
REQ-038 SHALL check async reset: assert rst_ni mid-stream between clock edges -> outputs clear immediately; after release, issue restarts at tag 0.

Source files
------------

// File: rtl/fpnew_result_rob.sv
// In-order result reorder buffer: out-of-order opgroup results are retired in allocation order.
// Optional FPNEW_ROB_BYPASS_EN forwards a result arriving for the head slot in the same cycle.
package fpnew_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module fpnew_result_rob #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic [$clog2(Depth)-1:0] op_tag_o,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [$clog2(Depth)-1:0] res_tag_i,
  input  logic [Width-1:0]         res_result_i,
  input  fpnew_pkg::status_t       res_status_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [Width-1:0]         out_result_o,
  output fpnew_pkg::status_t       out_status_o,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int unsigned IdxW = $clog2(Depth);
  localparam logic [IdxW:0] PtrOne = (IdxW+1)'(1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits on ready, and a held valid keeps its payload stable.
  logic [IdxW:0]      head_q, tail_q;
  logic [IdxW-1:0]    head_idx, tail_idx;
  logic [Depth-1:0]   pending_q, done_q;
  logic [Width-1:0]   result_q [Depth];
  fpnew_pkg::status_t status_q [Depth];
  logic               err_q;

  logic full, empty, alloc, retire, res_hit, res_take, res_bad, write, bypass;

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];
  assign full     = (head_q[IdxW] != tail_q[IdxW]) && (head_idx == tail_idx);
  assign empty    = (head_q == tail_q);

  assign op_valid_o = in_valid_i & ~full & ~flush_i;
  assign in_ready_o = op_ready_i & ~full & ~flush_i;
  assign op_tag_o   = tail_idx;
  assign alloc      = in_valid_i & in_ready_o;

  assign res_ready_o = 1'b1;
  assign res_hit     = pending_q[res_tag_i] & ~done_q[res_tag_i];
  assign res_take    = res_valid_i & ~flush_i & res_hit;
  assign res_bad     = res_valid_i & ~flush_i & ~res_hit;

`ifdef FPNEW_ROB_BYPASS_EN
  assign bypass = res_valid_i & ~flush_i & (res_tag_i == head_idx)
                & pending_q[head_idx] & ~done_q[head_idx];
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o  = ~flush_i & (done_q[head_idx] | bypass);
  assign out_result_o = bypass ? res_result_i : result_q[head_idx];
  assign out_status_o = bypass ? res_status_i : status_q[head_idx];
  assign retire       = out_valid_o & out_ready_i;
  // A bypassed result that retires immediately never needs its slot written.
  assign write        = res_take & ~(bypass & out_ready_i);

  assign busy_o = ~empty;
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else if (flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else begin
      if (alloc)  tail_q <= tail_q + PtrOne;
      if (retire) head_q <= head_q + PtrOne;
      // Alloc, capture and retire always address distinct slots, so ordering here is irrelevant.
      for (int i = 0; i < Depth; i++) begin
        if (alloc && (tail_idx == IdxW'(i))) begin
          pending_q[i] <= 1'b1;
          done_q[i]    <= 1'b0;
        end
        if (write && (res_tag_i == IdxW'(i))) done_q[i] <= 1'b1;
        if (retire && (head_idx == IdxW'(i))) begin
          pending_q[i] <= 1'b0;
          done_q[i]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (res_bad) err_q <= 1'b1;
  end

  // Payload storage carries no reset; done bits guard every read.
  always_ff @(posedge clk_i) begin
    if (write) begin
      result_q[res_tag_i] <= res_result_i;
      status_q[res_tag_i] <= res_status_i;
    end
  end
endmodule

// File: tb/tb_fpnew_result_rob.sv
// Directed plus randomized bench for fpnew_result_rob (Depth=4, Width=32) against a queue model.
module tb_fpnew_result_rob;
  localparam int D  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
`ifdef FPNEW_ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst_n, flush, in_valid, in_ready, op_valid, op_ready;
  logic [IW-1:0] op_tag, res_tag;
  logic res_valid, res_ready, out_valid, out_ready, busy, err;
  logic [W-1:0] res_result, out_result;
  fpnew_pkg::status_t res_status, out_status;

  int checks = 0;
  int errors = 0;

  fpnew_result_rob #(.Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_valid_o(op_valid), .op_ready_i(op_ready), .op_tag_o(op_tag),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .res_tag_i(res_tag),
    .res_result_i(res_result), .res_status_i(res_status),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_status_o(out_status),
    .busy_o(busy), .err_o(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic issue(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      #1;
      chk("issue_op_tag", 32'(op_tag), 32'((first + i) % D));
      chk("issue_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic ret(input int tag, input logic [W-1:0] val, input logic [4:0] st);
    res_valid  = 1'b1;
    res_tag    = IW'(tag);
    res_result = val;
    res_status = fpnew_pkg::status_t'(st);
    tick();
    res_valid  = 1'b0;
  endtask

  // Reference model: in-flight tags in allocation order plus per-tag result slots
  int           q[$];
  int           cand[$];
  int           alloc_cnt;
  bit           m_done [D];
  logic [W-1:0] m_res [D];
  logic [4:0]   m_st [D];
  bit           e_full, e_in_ready, e_op_valid, e_byp, e_out_valid;
  logic [W-1:0] e_res;
  logic [4:0]   e_st;
  int           tg;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op_ready = 1'b1;
    res_valid = 1'b0; res_tag = '0; res_result = '0; res_status = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_ready", 32'(res_ready), 32'd1);
    op_ready = 1'b0;
    #1;
    chk("rst_in_ready_follow", 32'(in_ready), 32'd0);
    op_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // In-order delivery of out-of-order results
    issue(0, 4);
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_op_valid", 32'(op_valid), 32'd0);
    in_valid = 1'b0;
    ret(2, 32'd102, 5'd7);
    #1;
    chk("order_wait_head", 32'(out_valid), 32'd0);
    ret(0, 32'd100, 5'd1);
    ret(3, 32'd103, 5'd10);
    ret(1, 32'd101, 5'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("order_valid", 32'(out_valid), 32'd1);
      chk("order_result", out_result, 32'(100 + k));
      chk("order_status", 32'(out_status), 32'(k * 3 + 1));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("order_drained_valid", 32'(out_valid), 32'd0);
    chk("order_drained_busy", 32'(busy), 32'd0);
    chk("order_err", 32'(err), 32'd0);

    // Full back-pressure and slot reuse
    issue(0, 4);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    ret(0, 32'h55, 5'd3);
    out_ready = 1'b1;
    #1;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_result", out_result, 32'h55);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_next_tag", 32'(op_tag), 32'd0);

    // Flush with three in flight (tags 1,2,3)
    ret(1, 32'h111, 5'd2);
    #1;
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1;
    res_valid = 1'b1; res_tag = 2'd3; res_result = 32'h333;
    #1;
    chk("fl_out_valid_comb", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_op_valid", 32'(op_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
    #1;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_err_clean", 32'(err), 32'd0);
    chk("fl_tag_zero", 32'(op_tag), 32'd0);
    ret(2, 32'h222, 5'd0);
    #1;
    chk("fl_late_err", 32'(err), 32'd1);
    chk("fl_late_busy", 32'(busy), 32'd0);

    // Duplicate result
    rst_n = 1'b0;
    #1;
    chk("dup_rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    issue(0, 2);
    ret(1, 32'hAAAA, 5'd9);
    #1;
    chk("dup_first_err", 32'(err), 32'd0);
    ret(1, 32'hBBBB, 5'd17);
    #1;
    chk("dup_err", 32'(err), 32'd1);
    ret(0, 32'h1000, 5'd5);
    out_ready = 1'b1;
    #1;
    chk("dup_out0", out_result, 32'h1000);
    tick();
    #1;
    chk("dup_out1_valid", 32'(out_valid), 32'd1);
    chk("dup_out1_result", out_result, 32'hAAAA);
    chk("dup_out1_status", 32'(out_status), 32'd9);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("dup_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset between edges
    issue(2, 1);
    ret(2, 32'h77, 5'd1);
    #1;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    issue(0, 1);

    // Result latency (same cycle only with bypass)
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(0, 1);
    out_ready = 1'b1;
    res_valid = 1'b1; res_tag = 2'd0; res_result = 32'h3F800000; res_status = 5'b10101;
    #1;
    chk("lat_same_cycle", 32'(out_valid), 32'(BYP));
    tick();
    res_valid = 1'b0;
    #1;
    chk("lat_next_cycle", 32'(out_valid), 32'(!BYP));
    tick();
    out_ready = 1'b0;
    #1;
    chk("lat_drained", 32'(busy), 32'd0);
    issue(1, 1);
    ret(1, 32'h3F800000, 5'b10101);
    #1;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_result", out_result, 32'h3F800000);
    chk("hold_status", 32'(out_status), 32'b10101);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized phase against the queue model
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    alloc_cnt = 0;
    for (int t = 0; t < D; t++) m_done[t] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op_ready  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 39) == 0);
      cand.delete();
      foreach (q[j]) if (!m_done[q[j]]) cand.push_back(q[j]);
      res_valid = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        res_valid  = 1'b1;
        res_tag    = IW'(cand[$urandom_range(0, cand.size() - 1)]);
        res_result = $urandom;
        res_status = fpnew_pkg::status_t'(5'($urandom));
      end
      #1;
      e_full      = (q.size() == D);
      e_in_ready  = op_ready && !e_full && !flush;
      e_op_valid  = in_valid && !e_full && !flush;
      e_byp       = BYP && res_valid && !flush && q.size() > 0
                    && (int'(res_tag) == q[0]) && !m_done[q[0]];
      e_out_valid = !flush && q.size() > 0 && (m_done[q[0]] || e_byp);
      chk("rnd_in_ready", 32'(in_ready), 32'(e_in_ready));
      chk("rnd_op_valid", 32'(op_valid), 32'(e_op_valid));
      chk("rnd_op_tag", 32'(op_tag), 32'(alloc_cnt % D));
      chk("rnd_out_valid", 32'(out_valid), 32'(e_out_valid));
      chk("rnd_busy", 32'(busy), 32'(q.size() > 0));
      chk("rnd_err", 32'(err), 32'd0);
      if (e_out_valid) begin
        e_res = e_byp ? res_result : m_res[q[0]];
        e_st  = e_byp ? 5'(res_status) : m_st[q[0]];
        chk("rnd_out_result", out_result, e_res);
        chk("rnd_out_status", 32'(out_status), 32'(e_st));
      end
      if (flush) begin
        q.delete();
        alloc_cnt = 0;
        for (int t = 0; t < D; t++) m_done[t] = 1'b0;
      end else begin
        if (res_valid && !(e_byp && out_ready)) begin
          tg         = int'(res_tag);
          m_done[tg] = 1'b1;
          m_res[tg]  = res_result;
          m_st[tg]   = 5'(res_status);
        end
        if (e_out_valid && out_ready) begin
          m_done[q[0]] = 1'b0;
          void'(q.pop_front());
        end
        if (in_valid && e_in_ready) begin
          q.push_back(alloc_cnt % D);
          alloc_cnt++;
        end
      end
      tick();
    end
    in_valid = 1'b0; res_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
